dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the MIPS32 single-cycle core (port C) and a
//  DMA/debug loader (port D). Registered-owner arbiter with park-on-CPU and bounded hold.

---
 rtl/dmem_arbiter_if.sv | 24 ++
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one memory-access bus (requester <-> owner of memory).
// master drives req/we/addr/wdata and sees rdata/gnt/stall; slave is the reverse.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              gnt;
    logic              stall;

    modport master (
        output req, we, addr, wdata,
        input  rdata, gnt, stall
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, gnt, stall
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU (port c)
// and a DMA/debug loader (port d). Registered owner, parks on CPU, and
// bounds how long one owner may hold memory while the other waits.
// Ports: clk, reset (async, active-high);
//   c   (slave)  : CPU bus, c.stall = c.req & ~c.gnt, c.rdata = mem.rdata
//   d   (slave)  : DMA bus, d.gnt = DMA owns memory this cycle
//   mem (master) : to dataMemory; mem.we is the memory write enable,
//                  mem.rdata is a combinational read
//   conflicts, c_stalls : statistics counters
// Optional feature macro DMEM_ARB_STATS_EN: when defined, conflicts and
// c_stalls are saturating counters; otherwise they are tied to zero.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    dmem_arbiter_if.slave    c,
    dmem_arbiter_if.slave    d,
    dmem_arbiter_if.master   mem,
    output logic [CNT_W-1:0] conflicts,
    output logic [CNT_W-1:0] c_stalls
);

    localparam int HC_W = $clog2(MAX_HOLD) + 1;

    localparam logic [0:0] OWN_C = 1'b0;
    localparam logic [0:0] OWN_D = 1'b1;

    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    logic [0:0]      owner;
    logic [0:0]      owner_nxt;
    logic [HC_W-1:0] hcnt;
    logic [HC_W-1:0] hcnt_nxt;

    logic c_gnt;
    logic d_gnt;
    logic own_req;
    logic own_we;
    logic oth_req;

    assign c_gnt = (owner == OWN_C);
    assign d_gnt = (owner == OWN_D);

    assign own_req = d_gnt ? d.req : c.req;
    assign own_we  = d_gnt ? d.we  : c.we;
    assign oth_req = d_gnt ? c.req : d.req;

    // Gate with reset so an in-flight write is cut off combinationally,
    // independent of what the CPU port is presenting at that instant.
    assign mem.req   = ~reset & own_req;
    assign mem.we    = ~reset & own_req & own_we;
    assign mem.addr  = d_gnt ? d.addr  : c.addr;
    assign mem.wdata = d_gnt ? d.wdata : c.wdata;

    assign c.rdata = mem.rdata;
    assign d.rdata = mem.rdata;

    assign c.gnt   = c_gnt;
    assign c.stall = c.req & ~c_gnt;
    assign d.gnt   = d_gnt;
    assign d.stall = d.req & ~d_gnt;

    always_comb begin
        owner_nxt = owner;
        hcnt_nxt  = '0;
        unique case ({own_req, oth_req})
            2'b01: owner_nxt = ~owner;
            2'b11: begin
                // contested: preempt once the owner used its hold budget
                if (hcnt == HOLD_LAST) begin
                    owner_nxt = ~owner;
                end else begin
                    hcnt_nxt = hcnt + 1'b1;
                end
            end
            2'b10: owner_nxt = owner;
            default: owner_nxt = OWN_C;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner <= OWN_C;
            hcnt  <= '0;
        end else begin
            owner <= owner_nxt;
            hcnt  <= hcnt_nxt;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [CNT_W-1:0] conf_q;
    logic [CNT_W-1:0] cst_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conf_q <= '0;
            cst_q  <= '0;
        end else begin
            if (c.req && d.req && (conf_q != '1)) begin
                conf_q <= conf_q + 1'b1;
            end
            if (c.stall && (cst_q != '1)) begin
                cst_q <= cst_q + 1'b1;
            end
        end
    end

    assign conflicts = conf_q;
    assign c_stalls  = cst_q;
`else
    assign conflicts = '0;
    assign c_stalls  = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a per-cycle scoreboard queue;
// a negedge monitor pops one expectation per cycle and compares.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) c_if ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) d_if ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

    logic [15:0] conflicts;
    logic [15:0] c_stalls;

    dmem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MAX_HOLD(4),
        .CNT_W   (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .c        (c_if.slave),
        .d        (d_if.slave),
        .mem      (m_if.master),
        .conflicts(conflicts),
        .c_stalls (c_stalls)
    );

    // Memory model: combinational read, write on rising edge.
    logic [31:0] mem_arr [0:255] = '{default: '0};

    assign m_if.rdata = mem_arr[m_if.addr[9:2]];
    assign m_if.gnt   = 1'b1;
    assign m_if.stall = 1'b0;

    always @(posedge clk) begin
        if (m_if.we) mem_arr[m_if.addr[9:2]] <= m_if.wdata;
    end

`ifdef DMEM_ARB_STATS_EN
    localparam logic [15:0] EXP_CF = 16'd10;
    localparam logic [15:0] EXP_ST = 16'd4;
`else
    localparam logic [15:0] EXP_CF = 16'd0;
    localparam logic [15:0] EXP_ST = 16'd0;
`endif

    typedef struct {
        string       tag;
        bit          stall;
        bit          dgnt;
        bit          mwr;
        bit          chk_data;
        logic [31:0] data;
        bit          chk_stats;
        logic [15:0] cf;
        logic [15:0] st;
    } ent_t;

    ent_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic expect_cyc(input string tag, input bit stall,
                              input bit dgnt, input bit mwr,
                              input bit cd = 1'b0,
                              input logic [31:0] data = '0,
                              input bit cs = 1'b0,
                              input logic [15:0] cf = '0,
                              input logic [15:0] st = '0);
        ent_t e;
        e.tag       = tag;
        e.stall     = stall;
        e.dgnt      = dgnt;
        e.mwr       = mwr;
        e.chk_data  = cd;
        e.data      = data;
        e.chk_stats = cs;
        e.cf        = cf;
        e.st        = st;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input bit rq, input bit we,
                         input logic [31:0] a, input logic [31:0] wd);
        c_if.req   = rq;
        c_if.we    = we;
        c_if.addr  = a;
        c_if.wdata = wd;
    endtask

    task automatic set_d(input bit rq, input bit we,
                         input logic [31:0] a, input logic [31:0] wd);
        d_if.req   = rq;
        d_if.we    = we;
        d_if.addr  = a;
        d_if.wdata = wd;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            ent_t e;
            bit   ok;
            e  = sb.pop_front();
            ok = (c_if.stall === e.stall) && (d_if.gnt === e.dgnt) &&
                 (m_if.we === e.mwr);
            if (e.chk_data) begin
                ok = ok && (c_if.rdata === e.data) && (d_if.rdata === e.data);
            end
            if (e.chk_stats) begin
                ok = ok && (conflicts === e.cf) && (c_stalls === e.st);
            end
            n_run++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s: got stall=%b dgnt=%b mwr=%b crd=%h drd=%h cf=%0d st=%0d; want stall=%b dgnt=%b mwr=%b rd=%h cf=%0d st=%0d",
                         e.tag, c_if.stall, d_if.gnt, m_if.we, c_if.rdata,
                         d_if.rdata, conflicts, c_stalls, e.stall, e.dgnt,
                         e.mwr, e.data, e.cf, e.st);
            end
        end
    end

    initial begin
        reset = 1'b1;
        set_c(0, 0, '0, '0);
        set_d(0, 0, '0, '0);
        tick();
        expect_cyc("rst", 0, 0, 0, 0, '0, 1, 16'd0, 16'd0);
        tick();
        reset = 1'b0;

        // CPU-only store then load
        set_c(1, 1, 32'h40, 32'hDEADBEEF);
        expect_cyc("c_sw", 0, 0, 1);
        tick();
        set_c(1, 0, 32'h40, '0);
        expect_cyc("c_lw", 0, 0, 0, 1, 32'hDEADBEEF);
        tick();

        // DMA from idle: one cycle switch latency, park on drop
        set_c(0, 0, '0, '0);
        set_d(1, 0, 32'h40, '0);
        expect_cyc("d_c0", 0, 0, 0);
        tick();
        expect_cyc("d_c1", 0, 1, 0, 1, 32'hDEADBEEF);
        tick();
        expect_cyc("d_c2", 0, 1, 0);
        tick();
        set_d(0, 0, '0, '0);
        expect_cyc("d_c3", 0, 1, 0);
        tick();
        expect_cyc("park", 0, 0, 0);
        tick();

        // Full contention: C x4, D x4, C
        set_c(1, 0, 32'h40, '0);
        set_d(1, 0, 32'h40, '0);
        for (int i = 0; i < 9; i++) begin
            bit dcyc;
            dcyc = (i >= 4) && (i < 8);
            expect_cyc($sformatf("cont%0d", i), dcyc, dcyc, 0);
            tick();
        end
        set_c(0, 0, '0, '0);
        set_d(0, 0, '0, '0);
        expect_cyc("idle1", 0, 0, 0);
        tick();

        // CPU write held off while DMA owns
        set_d(1, 1, 32'h10, 32'h11111111);
        expect_cyc("pre0", 0, 0, 0);
        tick();
        expect_cyc("pre1", 0, 1, 1);
        tick();
        set_d(1, 0, 32'h10, '0);
        set_c(1, 1, 32'h10, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            expect_cyc($sformatf("hold%0d", i), 1, 1, 0, 1, 32'h11111111);
            tick();
        end
        expect_cyc("c_wr", 0, 0, 1, 1, 32'h11111111);
        tick();
        set_c(1, 0, 32'h10, '0);
        expect_cyc("c_rd", 0, 0, 0, 1, 32'hCAFEF00D);
        tick();
        set_c(0, 0, '0, '0);
        set_d(0, 0, '0, '0);
        expect_cyc("idle2", 0, 0, 0);
        tick();

        // Reset in the middle of a DMA write burst
        set_d(1, 1, 32'h80, 32'h55AA55AA);
        expect_cyc("bw0", 0, 0, 0);
        tick();
        expect_cyc("bw1", 0, 1, 1);
        tick();
        set_d(1, 1, 32'h84, 32'h66666666);
        expect_cyc("bw2", 0, 1, 1);
        tick();
        set_d(1, 1, 32'h88, 32'h77777777);
        #2;
        reset = 1'b1;
        expect_cyc("rst_mid", 0, 0, 0);
        tick();
        expect_cyc("rst_hold", 0, 0, 0, 0, '0, 1, 16'd0, 16'd0);
        tick();
        reset = 1'b0;
        set_d(1, 0, 32'h88, '0);
        expect_cyc("post_rst", 0, 0, 0);
        tick();
        expect_cyc("drop88", 0, 1, 0, 1, 32'h00000000);
        tick();
        set_d(1, 0, 32'h84, '0);
        expect_cyc("keep84", 0, 1, 0, 1, 32'h66666666);
        tick();
        set_d(1, 0, 32'h80, '0);
        expect_cyc("keep80", 0, 1, 0, 1, 32'h55AA55AA);
        tick();
        set_d(0, 0, '0, '0);
        expect_cyc("idle3", 0, 1, 0);
        tick();

        // Statistics over 10 contention cycles
        reset = 1'b1;
        expect_cyc("rst2", 0, 0, 0);
        tick();
        reset = 1'b0;
        set_c(1, 0, 32'h40, '0);
        set_d(1, 0, 32'h40, '0);
        for (int i = 0; i < 10; i++) begin
            bit dcyc;
            dcyc = (i >= 4) && (i < 8);
            expect_cyc($sformatf("st%0d", i), dcyc, dcyc, 0);
            tick();
        end
        set_c(0, 0, '0, '0);
        set_d(0, 0, '0, '0);
        expect_cyc("stats", 0, 0, 0, 0, '0, 1, EXP_CF, EXP_ST);
        tick();

        for (int i = 0; i < 4 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
